// File: rtl/nios_128k_extended_key_pkg.sv
// Shared definitions for the debounced key/switch PIO.
//   - register word offsets on the slave bus
//   - EDGE_TYPE encodings and the per-bit edge qualifier
package nios_128k_extended_key_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_DIR     = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   function automatic logic edge_hit(input logic prev, input logic cur, input int edge_type);
      case (edge_type)
         EDGE_RISING:  return ~prev & cur;
         EDGE_FALLING: return prev & ~cur;
         default:      return prev ^ cur;
      endcase
   endfunction

endpackage

// File: rtl/nios_128k_extended_key_if.sv
// Avalon-MM style slave bus of the key PIO, plus its interrupt line.
//   address/chipselect/write_n/writedata : master -> slave
//   readdata/irq                         : slave -> master
interface nios_128k_extended_key_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );

endinterface

// File: rtl/nios_128k_extended_key_debounce.sv
// One input bit: two-flop synchronizer followed by a stability debouncer.
//   clk, reset_n : clock, async active-low reset
//   raw          : asynchronous external input
//   debounced    : value accepted after DEBOUNCE_CYCLES stable cycles
// Latency from a raw change to debounced is 2 + DEBOUNCE_CYCLES cycles.
module nios_128k_extended_key_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic debounced
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_1;
   logic          sync_2;
   logic          last;
   logic [CW-1:0] cnt;
   logic [CW-1:0] run_len;

   // The count restarts in the very cycle sync_2 changes (not one cycle
   // later via the registered copy), which keeps the latency at 2 + N.
   assign run_len = (sync_2 != last) ? '0 : cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_1    <= 1'b0;
         sync_2    <= 1'b0;
         last      <= 1'b0;
         cnt       <= '0;
         debounced <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
         last   <= sync_2;
         cnt    <= (run_len == CNT_MAX) ? run_len : run_len + CW'(1);
         if (run_len == CNT_MAX)
            debounced <= sync_2;
      end
   end

endmodule

// File: rtl/nios_128k_extended_key.sv
// Debounced key/switch PIO with edge capture and level interrupt.
//   clk, reset_n : clock, async active-low reset
//   in_port      : asynchronous key/switch inputs
//   bus          : slave bus (address, chipselect, write_n, writedata,
//                  readdata, irq)
// Registers: 0 data (RO), 1 reads 0, 2 irqmask (RW), 3 edgecapture (W1C).
module nios_128k_extended_key
   import nios_128k_extended_key_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_TYPE       = EDGE_RISING
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [WIDTH-1:0]         in_port,
   nios_128k_extended_key_if.slave  bus
);

   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] deb_q;
   logic [WIDTH-1:0] hit;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecap;
   logic [WIDTH-1:0] clr;
   logic [31:0]      rd_next;
   logic [31:0]      readdata_q;
   logic             wr;
   logic             unused_ok;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      nios_128k_extended_key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk       (clk),
         .reset_n   (reset_n),
         .raw       (in_port[i]),
         .debounced (deb[i])
      );
      assign hit[i] = edge_hit(deb_q[i], deb[i], EDGE_TYPE);
   end

   assign wr  = bus.chipselect & ~bus.write_n;
   assign clr = (wr && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

   // Upper write bits have no register behind them.
   assign unused_ok = &{1'b0, bus.writedata};

   always_comb begin
      rd_next = '0;
      case (bus.address)
         ADDR_DATA:    rd_next[WIDTH-1:0] = deb;
         ADDR_DIR:     rd_next = '0;
         ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
         ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_q      <= '0;
         irqmask    <= '0;
         edgecap    <= '0;
         readdata_q <= '0;
      end else begin
         deb_q      <= deb;
         readdata_q <= rd_next;
         if (wr && bus.address == ADDR_IRQMASK)
            irqmask <= bus.writedata[WIDTH-1:0];
         // A new edge overrides a simultaneous clear of the same bit.
         edgecap <= (edgecap & ~clr) | hit;
      end
   end

   assign bus.readdata = readdata_q;
   assign bus.irq      = |(edgecap & irqmask);

endmodule

// File: tb/tb_nios_128k_extended_key.sv
module tb_nios_128k_extended_key;
   import nios_128k_extended_key_pkg::*;

   localparam int W = 4;
   localparam int D = 16;

   logic         clk;
   logic         reset_n;
   logic [W-1:0] in_port;
   logic [W-1:0] in_port_f;

   int checks;
   int failures;

   nios_128k_extended_key_if bus ();
   nios_128k_extended_key_if bus_f ();

   nios_128k_extended_key #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(EDGE_RISING)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .in_port (in_port),
      .bus     (bus)
   );

   nios_128k_extended_key #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(EDGE_FALLING)) dut_f (
      .clk     (clk),
      .reset_n (reset_n),
      .in_port (in_port_f),
      .bus     (bus_f)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: the debounced value follows a bit once the samples
   // seen two cycles ago and the D-1 samples before them all agree.
   logic [W-1:0] hist [0:D];
   logic [W-1:0] deb_m, deb_old_m, mask_m, ecap_m;
   logic [31:0]  rd_m;

   function automatic logic [W-1:0] settled_value();
      logic [W-1:0] r;
      logic         same;
      r = deb_m;
      for (int b = 0; b < W; b++) begin
         same = 1'b1;
         for (int i = 2; i <= D; i++)
            if (hist[i][b] != hist[1][b]) same = 1'b0;
         if (same) r[b] = hist[1][b];
      end
      return r;
   endfunction

   function automatic logic [31:0] read_value(input logic [1:0] a);
      logic [31:0] r;
      r = '0;
      if (a == 2'd0) r[W-1:0] = deb_m;
      if (a == 2'd2) r[W-1:0] = mask_m;
      if (a == 2'd3) r[W-1:0] = ecap_m;
      return r;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i <= D; i++) hist[i] <= '0;
         deb_m     <= '0;
         deb_old_m <= '0;
         mask_m    <= '0;
         ecap_m    <= '0;
         rd_m      <= '0;
      end else begin
         rd_m      <= read_value(bus.address);
         deb_m     <= settled_value();
         deb_old_m <= deb_m;
         hist[0]   <= in_port;
         for (int i = 1; i <= D; i++) hist[i] <= hist[i-1];
         if (bus.chipselect && !bus.write_n && bus.address == 2'd2)
            mask_m <= bus.writedata[W-1:0];
         ecap_m <= (ecap_m & ~((bus.chipselect && !bus.write_n && bus.address == 2'd3)
                                ? bus.writedata[W-1:0] : '0))
                   | (deb_m & ~deb_old_m);
      end
   end

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.address    = a;
      bus.writedata  = d;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic test_reset();
      checks++;
      if (bus.readdata !== 32'h0 || bus.irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_held readdata=%h irq=%b expected 0/0", bus.readdata, bus.irq);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.address = 2'(k);
         @(negedge clk);
         checks++;
         if (bus.readdata !== 32'h0 || bus.irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs addr=%0d readdata=%h irq=%b expected 0/0", k, bus.readdata, bus.irq);
         end
      end
   endtask

   task automatic test_glitch();
      bus_write(2'd2, 32'hF);
      in_port = 4'b0010;
      for (int k = 1; k <= 40; k++) begin
         bus.address = (k % 2 == 0) ? 2'd0 : 2'd3;
         @(negedge clk);
         if (k == 10) in_port = 4'b0000;
         checks++;
         if (bus.readdata !== 32'h0 || bus.irq !== 1'b0) begin
            failures++;
            $display("FAIL glitch k=%0d readdata=%h irq=%b expected 0/0", k, bus.readdata, bus.irq);
         end
      end
   endtask

   task automatic test_stable_press();
      bus.address = 2'd3;
      in_port = 4'b0001;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         checks++;
         if (bus.readdata !== rd_m) begin
            failures++;
            $display("FAIL stable_model k=%0d readdata=%h expected=%h", k, bus.readdata, rd_m);
         end
         if (k == 19) begin
            checks++;
            if (bus.readdata !== 32'h0) begin
               failures++;
               $display("FAIL stable_early readdata=%h expected=0", bus.readdata);
            end
         end
         if (k == 20) begin
            checks++;
            if (bus.readdata !== 32'h1) begin
               failures++;
               $display("FAIL stable_capture readdata=%h expected=1", bus.readdata);
            end
         end
      end
      bus.address = 2'd0;
      @(negedge clk);
      checks++;
      if (bus.readdata !== 32'h1) begin
         failures++;
         $display("FAIL stable_data readdata=%h expected=1", bus.readdata);
      end
      bus_write(2'd3, 32'h1);
   endtask

   task automatic test_irq();
      bus_write(2'd2, 32'h4);
      in_port = 4'b0101;
      for (int k = 1; k <= 19; k++) begin
         @(negedge clk);
         if (k == 18) begin
            checks++;
            if (bus.irq !== 1'b0) begin
               failures++;
               $display("FAIL irq_early irq=%b expected=0", bus.irq);
            end
         end
      end
      checks++;
      if (bus.irq !== 1'b1) begin
         failures++;
         $display("FAIL irq_set irq=%b expected=1", bus.irq);
      end
      bus_write(2'd3, 32'h4);
      checks++;
      if (bus.irq !== 1'b0) begin
         failures++;
         $display("FAIL irq_clear irq=%b expected=0", bus.irq);
      end
      bus.address = 2'd3;
      @(negedge clk);
      checks++;
      if (bus.readdata !== 32'h0) begin
         failures++;
         $display("FAIL irq_edgecap readdata=%h expected=0", bus.readdata);
      end
   endtask

   task automatic test_edge_wins();
      in_port = 4'b1101;
      for (int k = 1; k <= 18; k++) @(negedge clk);
      bus_write(2'd3, 32'h8);
      bus.address = 2'd3;
      @(negedge clk);
      checks++;
      if (bus.readdata !== 32'h8 || bus.readdata !== rd_m) begin
         failures++;
         $display("FAIL edge_wins readdata=%h expected=8 model=%h", bus.readdata, rd_m);
      end
      bus_write(2'd3, 32'h8);
   endtask

   task automatic test_falling();
      in_port_f = 4'b0001;
      repeat (25) @(negedge clk);
      checks++;
      if (bus_f.readdata !== 32'h0) begin
         failures++;
         $display("FAIL fall_rise_ignored readdata=%h expected=0", bus_f.readdata);
      end
      bus_f.address = 2'd0;
      @(negedge clk);
      checks++;
      if (bus_f.readdata !== 32'h1) begin
         failures++;
         $display("FAIL fall_data readdata=%h expected=1", bus_f.readdata);
      end
      bus_f.address = 2'd3;
      in_port_f = 4'b0000;
      repeat (25) @(negedge clk);
      checks++;
      if (bus_f.readdata !== 32'h1) begin
         failures++;
         $display("FAIL fall_capture readdata=%h expected=1", bus_f.readdata);
      end
      bus_f.chipselect = 1'b1;
      bus_f.write_n    = 1'b0;
      bus_f.writedata  = 32'h1;
      @(negedge clk);
      bus_f.chipselect = 1'b0;
      bus_f.write_n    = 1'b1;
      in_port_f = 4'b0001;
      repeat (25) @(negedge clk);
      checks++;
      if (bus_f.readdata !== 32'h0 || bus_f.irq !== 1'b0) begin
         failures++;
         $display("FAIL fall_no_rise readdata=%h irq=%b expected 0/0", bus_f.readdata, bus_f.irq);
      end
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      for (int k = 0; k < 600; k++) begin
         if (hold == 0) begin
            in_port = W'($urandom);
            hold = $urandom_range(1, 24);
         end
         hold--;
         bus.address    = 2'($urandom);
         bus.chipselect = ($urandom_range(0, 3) == 0);
         bus.write_n    = 1'($urandom);
         bus.writedata  = $urandom;
         @(negedge clk);
         checks++;
         if (bus.readdata !== rd_m || bus.irq !== |(ecap_m & mask_m)) begin
            failures++;
            $display("FAIL random k=%0d readdata=%h expected=%h irq=%b expected=%b",
                     k, bus.readdata, rd_m, bus.irq, |(ecap_m & mask_m));
         end
      end
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic test_reset_async();
      in_port = 4'b0000;
      repeat (20) @(negedge clk);
      bus_write(2'd3, 32'hF);
      bus_write(2'd2, 32'hF);
      in_port = 4'b1111;
      bus.address = 2'd3;
      repeat (20) @(negedge clk);
      checks++;
      if (bus.irq !== 1'b1 || bus.readdata !== 32'hF) begin
         failures++;
         $display("FAIL async_pre irq=%b readdata=%h expected 1/f", bus.irq, bus.readdata);
      end
      in_port = 4'b0000;
      repeat (8) @(negedge clk);
      in_port = 4'b1111;
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (bus.irq !== 1'b0 || bus.readdata !== 32'h0) begin
         failures++;
         $display("FAIL async_reset irq=%b readdata=%h expected 0/0", bus.irq, bus.readdata);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         checks++;
         if (bus.readdata !== rd_m || bus.irq !== 1'b0) begin
            failures++;
            $display("FAIL async_release_model k=%0d readdata=%h expected=%h irq=%b",
                     k, bus.readdata, rd_m, bus.irq);
         end
         if (k == 19 || k == 20) begin
            checks++;
            if (bus.readdata !== ((k == 20) ? 32'hF : 32'h0)) begin
               failures++;
               $display("FAIL async_release_edge k=%0d readdata=%h expected=%h",
                        k, bus.readdata, (k == 20) ? 32'hF : 32'h0);
            end
         end
      end
      bus.address = 2'd2;
      @(negedge clk);
      checks++;
      if (bus.readdata !== 32'h0) begin
         failures++;
         $display("FAIL async_mask readdata=%h expected=0", bus.readdata);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      in_port   = '0;
      in_port_f = '0;
      bus.address    = 2'd0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      bus_f.address    = 2'd3;
      bus_f.chipselect = 1'b0;
      bus_f.write_n    = 1'b1;
      bus_f.writedata  = '0;
      repeat (3) @(negedge clk);

      test_reset();
      test_glitch();
      test_stable_press();
      test_irq();
      test_edge_wins();
      test_falling();
      test_random();
      test_reset_async();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
